inv_key_scheduler: RTL and testbench
====================================

Name: inv_key_scheduler

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Accepts the final round key (round NUM_ROUNDS) and streams round keys in reverse order, NUM_ROUNDS down to 0, one per handshake.
- Feeds AddRoundKey in the inverse-cipher round loop, so the decrypt side needs no 11-entry round-key RAM.
- Instantiates the existing forward S-box (SubWord) logic.

Parameters:
- NUM_ROUNDS, 10: index of the first key emitted. Legal range 1..10. Rcon table covers rounds 1..10.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_key is valid
- in_ready  output  1  block is idle and can accept a key
- in_key  input  128  round-NUM_ROUNDS key; [127:120] = FIPS byte 0; word0 = [127:96]
- out_valid  output  1  out_key is valid
- out_ready  input  1  consumer accepts out_key
- out_key  output  128  current round key
- out_round  output  4  round index of out_key
- out_last  output  1  high while out_round == 0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset wins over every other input, including mid-stream.
- Reset values: in_ready=1, out_valid=0, out_key=0, out_round=0, out_last=0; state=IDLE.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: out_key<=in_key, out_round<=NUM_ROUNDS, go to EMIT. Latency is 1 cycle, so out_valid is high in the cycle after acceptance.
  - EMIT: in_ready=0; in_valid is ignored.
    - On out_valid&&out_ready with out_round!=0: out_key<=prev(out_key, out_round), out_round<=out_round-1. Stay in EMIT with out_valid held high, giving one key per cycle under continuous ready.
    - On handshake with out_round==0: out_valid<=0, go to IDLE. in_ready rises the following cycle; no same-cycle reload.
- Backpressure: while out_valid&&!out_ready, out_key, out_round and out_last hold stable. No combinational path from out_ready to out_valid.
- prev(k, r), with k split into words k0..k3 from MSB:
  - p3=k3^k2; p2=k2^k1; p1=k1^k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - RotWord([a0,a1,a2,a3]) = [a1,a2,a3,a0]
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36
- out_last is registered, equal to (out_round==0) whenever out_valid=1, and 0 otherwise.
- A full stream is NUM_ROUNDS+1 handshakes. The first key is in_key passed through unmodified.
- out_round never wraps: no decrement occurs at round 0.

Optional Feature:
- Macro: INV_KEY_SCHED_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in EMIT forces IDLE at the next edge: out_valid=0, out_last=0, in_ready=1 the following cycle.
  - abort in IDLE has no effect.
  - abort takes priority over a simultaneous out handshake; that handshake is dropped and the key is not consumed.
- Undefined: no abort port; a stream is terminated only by completion or reset.

Test Plan:
- Case 1, FIPS-197 A.1, continuous out_ready=1:
  - Stimulus: in_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 10 equals in_key, then round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c with out_last=1.
  - Exactly 11 handshakes on consecutive cycles.
- Case 2, FIPS-197 C.1:
  - Stimulus: in_key=13111d7fe3944a17f307a78b4d2b30c5.
  - Round 0 out_key = 000102030405060708090a0b0c0d0e0f.
  - in_ready=1 one cycle after the final handshake.
- Case 3, random out_ready toggling on the A.1 key:
  - Key sequence identical to Case 1.
  - Outputs stable during every stall cycle.
  - in_valid pulses during EMIT are ignored, with in_ready=0.
- Case 4, reset asserted during round 5 of a stream:
  - Next cycle: out_valid=0, in_ready=1, out_round=0.
  - A new C.1 key is then accepted and produces the Case 2 sequence.
- Case 5, NUM_ROUNDS=1 build with in_key = A.1 round-1 key a0fafe17…7605:
  - Exactly 2 outputs; second = 2b7e151628aed2a6abf7158809cf4f3c with out_last=1.
- Case 6, INV_KEY_SCHED_ABORT_EN build:
  - abort asserted at out_round=7 together with out_ready=1.
  - out_valid=0 next cycle and the round-7 key is not consumed.
  - A reload of the A.1 key restarts from round 10.

Source files
------------

// File: rtl/inv_key_scheduler.sv
// AES-128 inverse key schedule: takes the final round key and walks back to round 0, one key per handshake.
// Optional build macro INV_KEY_SCHED_ABORT_EN adds an 'abort' input that drops an in-progress stream.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module inv_key_scheduler #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clock,
    input  logic         reset,
`ifdef INV_KEY_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         out_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_p3;
    logic [31:0]  sub_p3;
    logic [127:0] prev_key;

    assign k0 = out_key[127:96];
    assign k1 = out_key[95:64];
    assign k2 = out_key[63:32];
    assign k3 = out_key[31:0];

    assign p3     = k3 ^ k2;
    assign p2     = k2 ^ k1;
    assign p1     = k1 ^ k0;
    assign rot_p3 = {p3[23:0], p3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot_p3[8*g +: 8]),
            .out_byte (sub_p3[8*g +: 8])
        );
    end

    assign p0       = k0 ^ sub_p3 ^ {rcon(out_round), 24'h000000};
    assign prev_key = {p0, p1, p2, p3};

`ifdef INV_KEY_SCHED_ABORT_EN
    logic abort_req;
    assign abort_req = abort;
`else
    logic abort_req;
    assign abort_req = 1'b0;
`endif

    // out_valid is held high through the whole stream; only completion, abort or reset drops it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        out_key   <= in_key;
                        out_round <= 4'(NUM_ROUNDS);
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (abort_req) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else if (out_valid && out_ready) begin
                        if (out_round != 4'd0) begin
                            out_key   <= prev_key;
                            out_round <= out_round - 4'd1;
                            out_last  <= (out_round == 4'd1);
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Scoreboard bench for inv_key_scheduler: a NUM_ROUNDS=10 instance and a NUM_ROUNDS=1 instance.
// Build with INV_KEY_SCHED_ABORT_EN defined to also exercise abort.

module tb_inv_key_scheduler;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   round;
        logic         last;
        logic         chk;
    } exp_t;

    localparam logic [127:0] A1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    localparam logic [127:0] C1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] C1_R0  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_key = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, out_last;
    logic [127:0] out_key;
    logic [3:0]   out_round;

    logic         in_valid1 = 1'b0;
    logic [127:0] in_key1 = '0;
    logic         out_ready1 = 1'b1;
    logic         in_ready1, out_valid1, out_last1;
    logic [127:0] out_key1;
    logic [3:0]   out_round1;

    int checks = 0;
    int errors = 0;
    int hs0 = 0;
    int hs1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clock = ~clock;

    inv_key_scheduler #(.NUM_ROUNDS(10)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef INV_KEY_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .out_last  (out_last)
    );

    inv_key_scheduler #(.NUM_ROUNDS(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
`ifdef INV_KEY_SCHED_ABORT_EN
        .abort     (1'b0),
`endif
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_key    (in_key1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_key   (out_key1),
        .out_round (out_round1),
        .out_last  (out_last1)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out", name);
    endtask

    // Queue the expected outputs for rounds top..bottom of a stream.
    task automatic pushExpected(input bit sel, input bit use_c1, input int top, input int bottom);
        exp_t e;
        for (int r = top; r >= bottom; r--) begin
            e.round = 4'(r);
            e.last  = (r == 0);
            if (use_c1) begin
                e.chk = (r == 10 || r == 1 || r == 0);
                e.key = (r == 10) ? C1_R10 : (r == 1) ? C1_R1 : C1_R0;
            end else begin
                e.chk = 1'b1;
                e.key = A1[r];
            end
            if (sel) q1.push_back(e);
            else     q0.push_back(e);
        end
    endtask

    // Returns #1 after the edge that accepted the key.
    task automatic applyStimulus(input bit sel, input logic [127:0] key);
        int n = 0;
        @(posedge clock); #1;
        while (!(sel ? in_ready1 : in_ready) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) failNow("load_wait");
        if (sel) begin in_valid1 = 1'b1; in_key1 = key; end
        else     begin in_valid  = 1'b1; in_key  = key; end
        @(posedge clock); #1;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic waitDrain(input bit sel, input int budget);
        int n = 0;
        while ((sel ? (q1.size() != 0 || out_valid1) : (q0.size() != 0 || out_valid)) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= budget) failNow("drain");
    endtask

    logic         stall0 = 1'b0;
    logic [132:0] snap0 = '0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            stall0 = 1'b0;
        end else if (out_valid) begin
            if (stall0) checkOutput("stall_hold", 128'({out_key, out_round, out_last}), 128'(snap0));
            if (stall0 && ({out_key, out_round, out_last} !== snap0))
                $display("[TB] stall hold key %h round %0d", out_key, out_round);
            if (out_ready && !abort) begin
                hs0++;
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: got round %0d expected none", out_round);
                end else begin
                    e = q0.pop_front();
                    checkOutput("round", 128'(out_round), 128'(e.round));
                    checkOutput("last", 128'(out_last), 128'(e.last));
                    if (e.chk) checkOutput("key", out_key, e.key);
                end
            end
            stall0 = !out_ready;
            snap0  = {out_key, out_round, out_last};
        end else begin
            stall0 = 1'b0;
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid1 && out_ready1) begin
            hs1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out1: got round %0d expected none", out_round1);
            end else begin
                e = q1.pop_front();
                checkOutput("round1", 128'(out_round1), 128'(e.round));
                checkOutput("last1", 128'(out_last1), 128'(e.last));
                checkOutput("key1", out_key1, e.key);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_out_key", out_key, 128'(0));
        checkOutput("rst_out_round", 128'(out_round), 128'(0));
        checkOutput("rst_out_last", 128'(out_last), 128'(0));
        reset = 1'b0;

        $display("[TB] case 1: A.1 continuous ready");
        out_ready = 1'b1;
        base = hs0;
        pushExpected(0, 0, 10, 0);
        applyStimulus(0, A1[10]);
        repeat (10) @(posedge clock);
        #1;
        checkOutput("c1_valid_r0", 128'(out_valid), 128'(1));
        checkOutput("c1_last_r0", 128'(out_last), 128'(1));
        @(posedge clock); #1;
        checkOutput("c1_done_valid", 128'(out_valid), 128'(0));
        checkOutput("c1_done_ready", 128'(in_ready), 128'(1));
        checkOutput("c1_handshakes", 128'(hs0 - base), 128'(11));

        $display("[TB] case 2: C.1");
        pushExpected(0, 1, 10, 0);
        applyStimulus(0, C1_R10);
        waitDrain(0, 40);
        checkOutput("c2_in_ready", 128'(in_ready), 128'(1));

        $display("[TB] case 3: random backpressure");
        base = hs0;
        pushExpected(0, 0, 10, 0);
        out_ready = 1'b0;
        applyStimulus(0, A1[10]);
        n = 0;
        while (out_valid && n < 300) begin
            checkOutput("c3_in_ready", 128'(in_ready), 128'(0));
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_key    = {4{$urandom}};
            @(posedge clock); #1;
            n++;
        end
        in_valid = 1'b0;
        if (n >= 300) failNow("c3_stream");
        checkOutput("c3_handshakes", 128'(hs0 - base), 128'(11));
        checkOutput("c3_q_empty", 128'(q0.size()), 128'(0));

        $display("[TB] case 4: reset mid-stream");
        out_ready = 1'b1;
        pushExpected(0, 0, 10, 6);
        applyStimulus(0, A1[10]);
        n = 0;
        while (out_round != 4'd5 && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 30) failNow("c4_round5");
        out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        checkOutput("c4_valid", 128'(out_valid), 128'(0));
        checkOutput("c4_ready", 128'(in_ready), 128'(1));
        checkOutput("c4_round", 128'(out_round), 128'(0));
        checkOutput("c4_q_empty", 128'(q0.size()), 128'(0));
        out_ready = 1'b1;
        pushExpected(0, 1, 10, 0);
        applyStimulus(0, C1_R10);
        waitDrain(0, 40);
        checkOutput("c4_in_ready", 128'(in_ready), 128'(1));

        $display("[TB] case 5: NUM_ROUNDS=1");
        base = hs1;
        pushExpected(1, 0, 1, 0);
        applyStimulus(1, A1[1]);
        waitDrain(1, 20);
        checkOutput("c5_handshakes", 128'(hs1 - base), 128'(2));
        checkOutput("c5_in_ready", 128'(in_ready1), 128'(1));

`ifdef INV_KEY_SCHED_ABORT_EN
        $display("[TB] case 6: abort at round 7");
        out_ready = 1'b1;
        pushExpected(0, 0, 10, 8);
        applyStimulus(0, A1[10]);
        n = 0;
        while (out_round != 4'd7 && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 30) failNow("c6_round7");
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        checkOutput("c6_valid", 128'(out_valid), 128'(0));
        checkOutput("c6_last", 128'(out_last), 128'(0));
        checkOutput("c6_ready", 128'(in_ready), 128'(1));
        checkOutput("c6_round_kept", 128'(out_round), 128'(7));
        checkOutput("c6_key_kept", out_key, A1[7]);
        checkOutput("c6_q_empty", 128'(q0.size()), 128'(0));
        @(posedge clock); #1;
        checkOutput("c6_idle_ready", 128'(in_ready), 128'(1));
        pushExpected(0, 0, 10, 0);
        applyStimulus(0, A1[10]);
        waitDrain(0, 40);
`endif

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
